rv32_mtimer_multi: RTL and testbench
====================================

# rv32_mtimer_multi

Parametrised RISC-V machine-timer peripheral with an AXI4-Lite slave port: a 64-bit free-running `mtime`, a programmable prescaler, and `NUM_CMP` independent 64-bit `mtimecmp` comparators, each driving its own level interrupt. It is the multi-channel successor of the single-comparator RV32 timer IP. It sits on the PS-to-PL AXI interconnect and feeds the core's machine-timer interrupt, plus spare channels for auxiliary harts or FreeRTOS tick/trace timers.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: AXI data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 8: byte-address width; must satisfy 0x10 + 8*NUM_CMP ≤ 2^width.
- `NUM_CMP`, 4: number of comparator/interrupt channels, 1..30.
- `PRESCALE_W`, 16: prescaler register width.
- `S_AXI_ACLK` in 1: single clock, all logic rising-edge.
- `S_AXI_ARESET` in 1: reset. **Reset is synchronous and active-high.**
- `S_AXI_AWADDR` in C_S_AXI_ADDR_WIDTH; `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1: write address channel.
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1: write data channel.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1: write response channel.
- `S_AXI_ARADDR` in C_S_AXI_ADDR_WIDTH; `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1: read address channel.
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1: read data channel.
- `irq` out NUM_CMP: per-channel level interrupt; bit i high while mtime ≥ mtimecmp[i].

## Operation
- Register map (byte offsets, addr[1:0] ignored): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CTRL (bit0 EN, rest RAZ/WI), 0x0C PRESCALE, 0x10+8i MTIMECMP_LO[i], 0x14+8i MTIMECMP_HI[i].
- Unmapped offsets: reads return 0, writes are dropped; RESP always OKAY (2'b00).
- Writes honour WSTRB per byte.
- Prescaler: internal counter `pcnt` (PRESCALE_W bits). When EN=1, `tick` fires when pcnt == PRESCALE, then pcnt clears; otherwise pcnt increments. PRESCALE=0 ticks every cycle. When EN=0, pcnt holds.
- On tick, mtime increments by 1 as a full 64-bit value; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A software write to MTIME_LO/HI in the same cycle as a tick: the written bytes take the write value; unwritten bytes take the incremented value. Any write to PRESCALE clears pcnt.
- irq[i] is registered: next irq[i] = (mtime ≥ mtimecmp[i]), an unsigned 64-bit compare on the current register values.
- Write FSM: IDLE → (AWVALID & WVALID) → ACCEPT (AWREADY = WREADY = 1 for one cycle, register updated) → RESP (BVALID=1 until BREADY) → IDLE. AW without W, or W without AW, is not accepted.
- Read FSM: IDLE → ARVALID → ARREADY one cycle, RDATA captured → RVALID held until RREADY → IDLE. Read and write FSMs are independent and may run concurrently.

## Timing
- Reset values: mtime 0, pcnt 0, PRESCALE 0, EN 0, every mtimecmp 0xFFFF_FFFF_FFFF_FFFF, irq all 0, all READY/VALID 0, RDATA 0, BRESP/RRESP 0.
- Write: AWREADY/WREADY rise the cycle after both VALIDs are sampled high; the register holds the new value on the following edge; BVALID rises one cycle after the ready pulse.
- Read: ARREADY pulses the cycle after ARVALID; RVALID and RDATA are valid the next cycle and stay stable until RREADY.
- irq latency: 1 cycle after the mtime/mtimecmp register change. A mtimecmp write that raises the compare value drops irq 1 cycle after the register updates.
- Throughput: at most one write per 3 cycles and one read per 3 cycles.
- Reset mid-transaction aborts both FSMs to IDLE, drops VALIDs, and the in-flight write is lost.

## Configuration
- `RV32TIMER_SNAPSHOT_EN` defined: a read of MTIME_LO latches mtime[63:32] into a shadow register in the same cycle, and reads of MTIME_HI return the shadow. The lo-then-hi pair is therefore atomic. The shadow resets to 0.
- Undefined: MTIME_HI reads return live mtime[63:32]; no shadow register exists.

## Test plan
- Reset → read all registers: MTIME=0, CTRL=0, PRESCALE=0, MTIMECMP[i]=0xFFFFFFFF_FFFFFFFF, irq=0.
- PRESCALE=3, EN=1, wait 40 cycles → mtime advanced by 10 (±1); PRESCALE=0 → advances 1 per cycle.
- MTIMECMP[2]=0x0000_0000_0000_0064, EN=1, PRESCALE=0 → irq[2] rises 1 cycle after mtime reaches 0x64, other irq bits stay 0. Then write MTIMECMP[2]_LO=0xFFFF_FFFF → irq[2] falls.
- Write MTIME=0xFFFF_FFFF_FFFF_FFFE, EN=1 → wraps to 0 after 2 ticks; an asserted irq deasserts on wrap.
- With SNAPSHOT_EN: set MTIME=0x0000_0000_FFFF_FFFF, read LO then HI across the carry → returns {0, 0xFFFFFFFF} consistently. Without it, HI may read 1.
- WSTRB=4'b0010 write of 0xAABBCCDD to PRESCALE=0 → PRESCALE=0x0000CC00. BREADY held low for 5 cycles → BVALID stays high with BRESP=0.

Source files
------------

// File: rtl/rv32_mtimer_multi.sv
// rtl/rv32_mtimer_multi.sv - RISC-V machine timer with NUM_CMP mtimecmp channels on AXI4-Lite
// Optional feature macro: RV32TIMER_SNAPSHOT_EN (MTIME_LO read latches MTIME_HI into a shadow)
module rv32_mtimer_multi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_CMP            = 4,
  parameter int PRESCALE_W         = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CMP-1:0]              irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]                    wr_state, rd_state;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [31:0]                   wr_data, rd_val;
  logic [3:0]                    wr_strb;
  logic [63:0]                   mtime, mtime_inc;
  logic [63:0]                   mtimecmp [NUM_CMP];
  logic                          en, tick, wr_en;
  logic [PRESCALE_W-1:0]         prescale, pcnt;
  int                            wr_idx, rd_idx;
`ifdef RV32TIMER_SNAPSHOT_EN
  logic [31:0]                   mtime_hi_shadow;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? d[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  assign wr_idx        = int'(wr_addr >> 2);
  assign rd_idx        = int'(rd_addr >> 2);
  assign wr_en         = (wr_state == ST_ACCEPT);
  assign S_AXI_AWREADY = (wr_state == ST_ACCEPT);
  assign S_AXI_WREADY  = (wr_state == ST_ACCEPT);
  assign S_AXI_BVALID  = (wr_state == ST_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = (rd_state == ST_ACCEPT);
  assign S_AXI_RVALID  = (rd_state == ST_RESP);
  assign S_AXI_RRESP   = 2'b00;

  always_comb begin
    tick      = en && (pcnt == prescale);
    mtime_inc = tick ? mtime + 64'd1 : mtime;
  end

  // Software writes override only the strobed bytes; the rest keep the ticked value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      mtime    <= '0;
      pcnt     <= '0;
      prescale <= '0;
      en       <= 1'b0;
    end else begin
      mtime[31:0]  <= (wr_en && wr_idx == 0) ? merge(mtime_inc[31:0], wr_data, wr_strb)
                                             : mtime_inc[31:0];
      mtime[63:32] <= (wr_en && wr_idx == 1) ? merge(mtime_inc[63:32], wr_data, wr_strb)
                                             : mtime_inc[63:32];
      if (wr_en && wr_idx == 2 && wr_strb[0]) en <= wr_data[0];
      if (wr_en && wr_idx == 3) begin
        prescale <= PRESCALE_W'(merge(32'(prescale), wr_data, wr_strb));
        pcnt     <= '0;
      end else if (tick) begin
        pcnt <= '0;
      end else if (en) begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_CMP; i++) mtimecmp[i] <= '1;
      irq <= '0;
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        if (wr_en && wr_idx == 4 + 2*i)
          mtimecmp[i][31:0] <= merge(mtimecmp[i][31:0], wr_data, wr_strb);
        if (wr_en && wr_idx == 5 + 2*i)
          mtimecmp[i][63:32] <= merge(mtimecmp[i][63:32], wr_data, wr_strb);
        irq[i] <= (mtime >= mtimecmp[i]);
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_state <= ST_IDLE;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_strb  <= '0;
    end else begin
      case (wr_state)
        ST_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
          wr_addr  <= S_AXI_AWADDR;
          wr_data  <= S_AXI_WDATA;
          wr_strb  <= S_AXI_WSTRB;
          wr_state <= ST_ACCEPT;
        end
        ST_ACCEPT: wr_state <= ST_RESP;
        ST_RESP:   if (S_AXI_BREADY) wr_state <= ST_IDLE;
        default:   wr_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      0: rd_val = mtime[31:0];
`ifdef RV32TIMER_SNAPSHOT_EN
      1: rd_val = mtime_hi_shadow;
`else
      1: rd_val = mtime[63:32];
`endif
      2: rd_val = {31'd0, en};
      3: rd_val = 32'(prescale);
      default: rd_val = '0;
    endcase
    for (int i = 0; i < NUM_CMP; i++) begin
      if (rd_idx == 4 + 2*i) rd_val = mtimecmp[i][31:0];
      if (rd_idx == 5 + 2*i) rd_val = mtimecmp[i][63:32];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_state    <= ST_IDLE;
      rd_addr     <= '0;
      S_AXI_RDATA <= '0;
`ifdef RV32TIMER_SNAPSHOT_EN
      mtime_hi_shadow <= '0;
`endif
    end else begin
      case (rd_state)
        ST_IDLE: if (S_AXI_ARVALID) begin
          rd_addr  <= S_AXI_ARADDR;
          rd_state <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          S_AXI_RDATA <= rd_val;
`ifdef RV32TIMER_SNAPSHOT_EN
          if (rd_idx == 0) mtime_hi_shadow <= mtime[63:32];
`endif
          rd_state <= ST_RESP;
        end
        ST_RESP: if (S_AXI_RREADY) rd_state <= ST_IDLE;
        default: rd_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mtimer_multi.sv
// tb/tb_rv32_mtimer_multi.sv - directed self-checking bench for rv32_mtimer_multi
module tb_rv32_mtimer_multi;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, d;
  logic [3:0]  irq;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  rv32_mtimer_multi dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(arst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] v, input logic [3:0] s);
    @(posedge clk); #1;
    awaddr = a; wdata = v; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (awready) break;
    end
    check("aw_handshake", {63'd0, awready & wready}, 64'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bvalid) break;
    end
    check("b_valid", {63'd0, bvalid}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (arready) break;
    end
    check("ar_handshake", {63'd0, arready}, 64'd1);
    arvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (rvalid) break;
    end
    check("r_valid", {63'd0, rvalid}, 64'd1);
    v = rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;

    // reset state
    check("rst_irq", {60'd0, irq}, 64'd0);
    check("rst_bvalid", {63'd0, bvalid}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_ready", {62'd0, awready, arready}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    for (int k = 0; k < 13; k++) begin
      axi_read(8'(4*k), d);
      check($sformatf("rst_reg_%0d", k), {32'd0, d},
            (k < 4 || k == 12) ? 64'd0 : 64'h0000_0000_FFFF_FFFF);
    end

    // prescaler 3: 44 enabled edges -> 11 ticks
    axi_write(8'h0C, 32'd3, 4'hF);
    axi_write(8'h08, 32'd1, 4'hF);
    repeat (40) @(posedge clk);
    axi_write(8'h08, 32'd0, 4'hF);
    axi_read(8'h00, d);
    check("presc3_mtime", {32'd0, d}, 64'd11);

    // prescaler 0: 24 enabled edges -> 24 ticks
    axi_write(8'h0C, 32'd0, 4'hF);
    axi_write(8'h08, 32'd1, 4'hF);
    repeat (20) @(posedge clk);
    axi_write(8'h08, 32'd0, 4'hF);
    axi_read(8'h00, d);
    check("presc0_mtime", {32'd0, d}, 64'd35);

    // compare channel 2 at 0x64
    axi_write(8'h00, 32'd0, 4'hF);
    axi_write(8'h20, 32'h64, 4'hF);
    axi_write(8'h24, 32'h0, 4'hF);
    check("cmp2_idle_irq", {60'd0, irq}, 64'd0);
    axi_write(8'h08, 32'd1, 4'hF);
    repeat (99) @(posedge clk);
    #1 check("cmp2_before", {60'd0, irq}, 64'd0);
    @(posedge clk); #1;
    check("cmp2_rise", {60'd0, irq}, 64'h4);
    axi_write(8'h20, 32'hFFFF_FFFF, 4'hF);
    check("cmp2_fall", {60'd0, irq}, 64'd0);

    // 64-bit wrap
    axi_write(8'h08, 32'd0, 4'hF);
    axi_write(8'h04, 32'hFFFF_FFFF, 4'hF);
    axi_write(8'h00, 32'hFFFF_FFFE, 4'hF);
    axi_write(8'h10, 32'h10, 4'hF);
    axi_write(8'h14, 32'h0, 4'hF);
    check("wrap_pre_irq", {60'd0, irq}, 64'h5);
    axi_write(8'h08, 32'd1, 4'hF);
    @(posedge clk); #1;
    check("wrap_max_irq", {60'd0, irq}, 64'hF);
    @(posedge clk); #1;
    check("wrap_zero_irq", {60'd0, irq}, 64'd0);
    axi_write(8'h08, 32'd0, 4'hF);
    axi_read(8'h00, d);
    check("wrap_lo", {32'd0, d}, 64'd4);
    axi_read(8'h04, d);
    check("wrap_hi", {32'd0, d}, 64'd0);

    // lo/hi read across a carry (prescale 7, tick lands on the HI capture edge)
    axi_write(8'h0C, 32'd7, 4'hF);
    axi_write(8'h00, 32'hFFFF_FFFF, 4'hF);
    axi_write(8'h04, 32'h0, 4'hF);
    axi_write(8'h08, 32'd1, 4'hF);
    axi_read(8'h00, d);
    check("carry_lo", {32'd0, d}, 64'hFFFF_FFFF);
    axi_read(8'h04, d);
    check("carry_hi", {32'd0, d}, 64'd0);
    axi_read(8'h04, d);
`ifdef RV32TIMER_SNAPSHOT_EN
    check("carry_hi_later", {32'd0, d}, 64'd0);
`else
    check("carry_hi_later", {32'd0, d}, 64'd1);
`endif
    axi_write(8'h08, 32'd0, 4'hF);

    // byte strobes
    axi_write(8'h0C, 32'd0, 4'hF);
    axi_write(8'h0C, 32'hAABB_CCDD, 4'b0010);
    axi_read(8'h0C, d);
    check("wstrb_presc", {32'd0, d}, 64'h0000_CC00);

    // BREADY held low: response must persist
    bready = 1'b0;
    @(posedge clk); #1;
    awaddr = 8'h08; wdata = 32'd0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (awready) break;
    end
    check("hold_aw", {63'd0, awready}, 64'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check($sformatf("hold_bvalid_%0d", n), {61'd0, bvalid, bresp}, 64'h4);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", {63'd0, bvalid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
